// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: RISC-V load/store funct3
// codes, FSM state encoding and requester identifiers.
package mem_port_arbiter_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes (share encodings with the signed loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Transaction FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Requester identifiers
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_lsu_lane_align.sv
// Combinational lane formatter for load/store sub-word accesses: byte
// enables, store-data replication, load-data alignment/extension and
// detection of misaligned or illegal accesses.
module lsu_lane_align
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic            we,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext,
    output logic            err
);

    logic [XLEN-1:0]        shifted;
    logic signed [7:0]      byte_s;
    logic signed [15:0]     half_s;

    // Decode size, build lane enables/replicated data and extend load data
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = '0;
        err       = 1'b0;
        shifted   = mem_rdata >> {off, 3'b000};
        byte_s    = shifted[7:0];
        half_s    = shifted[15:0];
        case (funct3)
            F3_LB: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = XLEN'(byte_s);
            end
            F3_LH: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = XLEN'(half_s);
                err       = off[0];
            end
            F3_LW: begin
                be        = 4'b1111;
                rdata_ext = mem_rdata;
                err       = (off != 2'b00);
            end
            F3_LBU: begin
                be        = 4'b0001 << off;
                rdata_ext = XLEN'($unsigned(byte_s));
                err       = we;
            end
            F3_LHU: begin
                be        = 4'b0011 << off;
                rdata_ext = XLEN'($unsigned(half_s));
                err       = we | off[0];
            end
            default: begin
                err       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between instruction fetch
// and load/store, one transaction at a time: IDLE -> ISSUE -> WAIT -> RESP,
// with arbitration in RESP so back-to-back accesses take three cycles each.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit LS_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [2:0]      ls_funct3,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [XLEN-1:0] mem_rdata
);

    state_t          state_q;
    state_t          state_d;
    logic            last_grant_q;
    logic            owner_q;
    logic            take;
    logic            winner;
    logic            arb_en;

    // Captured request fields (stage 0: valid ISSUE through RESP)
    logic [XLEN-1:0] addr_p0;
    logic [2:0]      funct3_p0;
    logic            we_p0;
    logic [XLEN-1:0] wdata_p0;

    // Formatted response (stage 1: valid in RESP)
    logic [XLEN-1:0] rdata_p1;
    logic            err_p1;

    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_err;

    logic            issue;
    logic            resp;
    logic            is_ls;

    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign issue  = (state_q == ST_ISSUE);
    assign resp   = (state_q == ST_RESP);
    assign is_ls  = (owner_q == REQ_LS);

    // Pick a winner; on contention the requester not granted last time wins
    always_comb begin
        take   = 1'b0;
        winner = last_grant_q;
        if (arb_en) begin
            if (if_req && ls_req) begin
                take   = 1'b1;
                winner = (last_grant_q == REQ_LS) ? REQ_IF : REQ_LS;
            end else if (ls_req) begin
                take   = 1'b1;
                winner = REQ_LS;
            end else if (if_req) begin
                take   = 1'b1;
                winner = REQ_IF;
            end
        end
    end

    // Next-state logic for the transaction FSM
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = take ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  state_d = take ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, fairness pointer and current owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LS_FIRST ? REQ_IF : REQ_LS;
            owner_q      <= REQ_IF;
        end else begin
            state_q <= state_d;
            if (take) begin
                last_grant_q <= winner;
                owner_q      <= winner;
            end
        end
    end

    // Stage 0: capture the winning requester's fields at arbitration
    always_ff @(posedge clk) begin
        if (take) begin
            if (winner == REQ_LS) begin
                addr_p0   <= ls_addr;
                funct3_p0 <= ls_funct3;
                we_p0     <= ls_we;
            end else begin
                addr_p0   <= if_addr;
                funct3_p0 <= F3_LW;
                we_p0     <= 1'b0;
            end
            wdata_p0 <= ls_wdata;
        end
    end

    lsu_lane_align #(
        .XLEN      (XLEN)
    ) u_align (
        .funct3    (funct3_p0),
        .we        (we_p0),
        .off       (addr_p0[1:0]),
        .wdata     (wdata_p0),
        .mem_rdata (mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .err       (al_err)
    );

    // Stage 1: register formatted read data at the end of WAIT
    always_ff @(posedge clk) begin
        if (state_q == ST_WAIT) begin
            if (!is_ls)
                rdata_p1 <= mem_rdata;
            else if (we_p0 || al_err)
                rdata_p1 <= '0;
            else
                rdata_p1 <= al_rdata;
            err_p1 <= is_ls && al_err;
        end
    end

    // Memory port and requester handshakes, all qualified by FSM state so
    // they are zero outside their cycle and drop at once on reset
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (issue) begin
            mem_addr = {addr_p0[XLEN-1:2], 2'b00};
            if (!is_ls) begin
                mem_be = 4'b1111;
                mem_re = 1'b1;
            end else if (!al_err) begin
                mem_be    = al_be;
                mem_wdata = al_wdata;
                mem_re    = !we_p0;
                mem_we    = we_p0;
            end
        end
    end

    assign if_gnt    = issue && !is_ls;
    assign ls_gnt    = issue && is_ls;
    assign if_rvalid = resp && !is_ls;
    assign ls_rvalid = resp && is_ls;
    assign if_rdata  = if_rvalid ? rdata_p1 : '0;
    assign ls_rdata  = ls_rvalid ? rdata_p1 : '0;
    assign ls_err    = ls_rvalid && err_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, sub-word loads/stores, error
// cases, contention ordering and reset in the middle of a store.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .XLEN      (32),
        .LS_FIRST  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_funct3 (ls_funct3),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One LS transaction from request to completion, checked every cycle
    task automatic do_ls(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] mrd, input logic exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd);
        ls_req    = 1'b1;
        ls_we     = we;
        ls_funct3 = f3;
        ls_addr   = addr;
        ls_wdata  = wd;
        mem_rdata = mrd;
        step();
        chk({tag, ".gnt"}, {31'b0, ls_gnt}, 32'd1);
        chk({tag, ".re"},  {31'b0, mem_re}, {31'b0, !exp_err && !we});
        chk({tag, ".we"},  {31'b0, mem_we}, {31'b0, !exp_err && we});
        if (!exp_err) begin
            chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
            chk({tag, ".be"},   {28'b0, mem_be}, {28'b0, exp_be});
            if (we) chk({tag, ".wdata"}, mem_wdata, exp_wd);
        end
        ls_req = 1'b0;
        step();
        chk({tag, ".wait"}, {29'b0, ls_gnt, mem_re, mem_we}, 32'd0);
        step();
        chk({tag, ".rvalid"}, {31'b0, ls_rvalid}, 32'd1);
        chk({tag, ".rdata"},  ls_rdata, exp_rd);
        chk({tag, ".err"},    {31'b0, ls_err}, {31'b0, exp_err});
        step();
        chk({tag, ".idle"}, {31'b0, ls_rvalid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if_addr   = '0;
        ls_we     = 1'b0;
        ls_funct3 = 3'b000;
        ls_addr   = '0;
        ls_wdata  = '0;
        mem_rdata = '0;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        ls_req    = 1'b0;
        #2;
        chk("reset.ctl", {26'b0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_we}, 32'd0);
        chk("reset.mem", {mem_addr | mem_wdata | ls_rdata | if_rdata}, 32'd0);
        chk("reset.ports", {27'b0, mem_re, mem_be}, 32'd0);
        do_reset();

        // Instruction fetch only
        if_req    = 1'b1;
        if_addr   = 32'h0000_0104;
        mem_rdata = 32'h00A0_0093;
        step();
        chk("fetch.gnt",  {31'b0, if_gnt}, 32'd1);
        chk("fetch.addr", mem_addr, 32'h0000_0104);
        chk("fetch.re",   {31'b0, mem_re}, 32'd1);
        chk("fetch.be",   {28'b0, mem_be}, 32'hF);
        if_req = 1'b0;
        step();
        chk("fetch.wait", {31'b0, if_rvalid}, 32'd0);
        step();
        chk("fetch.rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("fetch.rdata",  if_rdata, 32'h00A0_0093);
        step();
        chk("fetch.idle", {31'b0, if_rvalid}, 32'd0);

        // Loads, stores and error cases
        do_ls("lb",   1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_ls("lbu",  1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 1'b0, 4'b1000, 32'h0, 32'h0000_0080);
        do_ls("lh",   1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_ls("lhu",  1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 1'b0, 4'b1100, 32'h0, 32'h0000_8001);
        do_ls("lw",   1'b0, 3'b010, 32'h400, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        do_ls("sh",   1'b1, 3'b001, 32'h302, 32'h0000_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        do_ls("sb",   1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        do_ls("sw",   1'b1, 3'b010, 32'h200, 32'h1234_5678, 32'h0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0);
        do_ls("lw_mis", 1'b0, 3'b010, 32'h401, 32'h0, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_ls("lh_mis", 1'b0, 3'b001, 32'h103, 32'h0, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_ls("sbu_ill", 1'b1, 3'b100, 32'h100, 32'h1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);
        do_ls("f3_ill",  1'b0, 3'b011, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b1, 4'b0000, 32'h0, 32'h0);

        // Contention from reset: LS, IF, LS, IF with no idle gaps
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h0000_0040;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        ls_funct3 = 3'b010;
        ls_addr   = 32'h0000_0080;
        mem_rdata = 32'h1111_2222;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("arb%0d.gnt", k), {30'b0, ls_gnt, if_gnt},
                (k % 2 == 0) ? 32'd2 : 32'd1);
            step();
            chk($sformatf("arb%0d.wait", k), {30'b0, ls_gnt, if_gnt}, 32'd0);
            step();
            chk($sformatf("arb%0d.rvalid", k), {30'b0, ls_rvalid, if_rvalid},
                (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 3) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
        end
        step();
        chk("arb.idle", {28'b0, ls_gnt, if_gnt, ls_rvalid, if_rvalid}, 32'd0);

        // Reset asserted while a store is being issued
        ls_req    = 1'b1;
        ls_we     = 1'b1;
        ls_funct3 = 3'b010;
        ls_addr   = 32'h0000_0500;
        ls_wdata  = 32'hCAFE_F00D;
        step();
        chk("rst_sw.we_before", {31'b0, mem_we}, 32'd1);
        rst_n  = 1'b0;
        ls_req = 1'b0;
        #1;
        chk("rst_sw.we_after", {31'b0, mem_we}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_sw.no_rvalid%0d", k), {30'b0, ls_rvalid, mem_we}, 32'd0);
        end
        do_ls("post_rst", 1'b0, 3'b010, 32'h600, 32'h0, 32'h5A5A_0F0F, 1'b0, 4'b1111, 32'h0, 32'h5A5A_0F0F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
